// File: rtl/dcache_pkg.sv
// Shared types and field geometry for the direct-mapped L1 data cache.
package dcache_pkg;

    localparam int unsigned OFF_W = 5;
    localparam int unsigned IDX_W = 5;
    localparam int unsigned TAG_W = 32 - IDX_W - OFF_W;

    localparam int unsigned WORD_LSB = 2;
    localparam int unsigned IDX_LSB  = OFF_W;
    localparam int unsigned TAG_LSB  = OFF_W + IDX_W;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWback = 2'd1,
        StFetch = 2'd2,
        StFill  = 2'd3
    } dcacheState_e;

endpackage

// File: rtl/dcache_store.sv
// Tag, valid, dirty and data arrays: one combinational read port, a word write and a line write.
module dcache_store
    import dcache_pkg::*;
#(
    parameter int unsigned LINES  = 32,
    parameter int unsigned LINE_W = 256,
    parameter int unsigned TagW   = 22
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [$clog2(LINES)-1:0]      rdIdx,
    output logic                          rdValid,
    output logic                          rdDirty,
    output logic [TagW-1:0]               rdTag,
    output logic [LINE_W-1:0]             rdLine,
    input  logic                          wordWe,
    input  logic [$clog2(LINES)-1:0]      wordIdx,
    input  logic [$clog2(LINE_W/32)-1:0]  wordSel,
    input  logic [31:0]                   wordData,
    input  logic                          lineWe,
    input  logic [$clog2(LINES)-1:0]      lineIdx,
    input  logic [TagW-1:0]               lineTag,
    input  logic [LINE_W-1:0]             lineData
);

    logic [LINES-1:0]  validQ;
    logic [LINES-1:0]  dirtyQ;
    logic [TagW-1:0]   tagQ  [LINES];
    logic [LINE_W-1:0] dataQ [LINES];

    assign rdValid = validQ[rdIdx];
    assign rdDirty = dirtyQ[rdIdx];
    assign rdTag   = tagQ[rdIdx];
    assign rdLine  = dataQ[rdIdx];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            validQ <= '0;
            dirtyQ <= '0;
        end else if (lineWe) begin
            validQ[lineIdx] <= 1'b1;
            dirtyQ[lineIdx] <= 1'b0;
        end else if (wordWe) begin
            dirtyQ[wordIdx] <= 1'b1;
        end
    end

    // Tag and data contents are meaningless until valid is set, so they carry no reset.
    always_ff @(posedge clk_i) begin
        if (lineWe) begin
            tagQ[lineIdx]  <= lineTag;
            dataQ[lineIdx] <= lineData;
        end else if (wordWe) begin
            dataQ[wordIdx][{wordSel, 5'b0} +: 32] <= wordData;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate L1 data-cache controller for the MEM stage.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int unsigned LINES  = 32,
    parameter int unsigned LINE_W = 256,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_rd_i,
    input  logic              cpu_wr_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              stall_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    localparam int unsigned IdxW  = $clog2(LINES);
    localparam int unsigned TagW  = ADDR_W - IdxW - OFF_W;
    localparam int unsigned WselW = $clog2(LINE_W / 32);

    dcacheState_e      stateQ, stateD;
    logic [TagW-1:0]   missTagQ, victimTagQ;
    logic [IdxW-1:0]   missIdxQ;
    logic [LINE_W-1:0] fillQ;

    logic [TagW-1:0]   cpuTag;
    logic [IdxW-1:0]   cpuIdx, rdIdx;
    logic [WselW-1:0]  cpuWord;
    logic              req, idle, hit, serve, missStart;
    logic              rdValid, rdDirty, wordWe, lineWe;
    logic [TagW-1:0]   rdTag;
    logic [LINE_W-1:0] rdLine;
    logic              unusedByteOff;

    assign cpuTag        = cpu_addr_i[ADDR_W-1 -: TagW];
    assign cpuIdx        = cpu_addr_i[OFF_W +: IdxW];
    assign cpuWord       = cpu_addr_i[WORD_LSB +: WselW];
    assign unusedByteOff = ^cpu_addr_i[WORD_LSB-1:0];

    assign req       = cpu_rd_i | cpu_wr_i;
    assign idle      = (stateQ == StIdle);
    // While a miss is in flight the read port follows the miss line to source the victim.
    assign rdIdx     = idle ? cpuIdx : missIdxQ;
    assign hit       = rdValid & (rdTag == cpuTag);
    assign serve     = idle & hit;
    assign missStart = idle & req & ~hit;

    assign stall_o     = rst_i & req & ~serve;
    assign cpu_rdata_o = (cpu_rd_i && serve) ? rdLine[{cpuWord, 5'b0} +: 32] : '0;

    dcache_store #(
        .LINES  (LINES),
        .LINE_W (LINE_W),
        .TagW   (TagW)
    ) uStore (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rdIdx    (rdIdx),
        .rdValid  (rdValid),
        .rdDirty  (rdDirty),
        .rdTag    (rdTag),
        .rdLine   (rdLine),
        .wordWe   (wordWe),
        .wordIdx  (cpuIdx),
        .wordSel  (cpuWord),
        .wordData (cpu_wdata_i),
        .lineWe   (lineWe),
        .lineIdx  (missIdxQ),
        .lineTag  (missTagQ),
        .lineData (fillQ)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            missTagQ   <= '0;
            missIdxQ   <= '0;
            victimTagQ <= '0;
            fillQ      <= '0;
        end else begin
            if (missStart) begin
                missTagQ   <= cpuTag;
                missIdxQ   <= cpuIdx;
                victimTagQ <= rdTag;
            end
            if (stateQ == StFetch && mem_ack_i) begin
                fillQ <= mem_rdata_i;
            end
        end
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle:  if (missStart) stateD = (rdValid && rdDirty) ? StWback : StFetch;
            StWback: if (mem_ack_i) stateD = StFetch;
            StFetch: if (mem_ack_i) stateD = StFill;
            StFill:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        wordWe      = cpu_wr_i & serve;
        lineWe      = 1'b0;
        unique case (stateQ)
            StWback: begin
                mem_en_o    = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {victimTagQ, missIdxQ, {OFF_W{1'b0}}};
                mem_wdata_o = rdLine;
            end
            StFetch: begin
                mem_en_o   = 1'b1;
                mem_addr_o = {missTagQ, missIdxQ, {OFF_W{1'b0}}};
            end
            StFill:  lineWe = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate L1 data-cache controller in the MEM stage.
- Serves the load/store request held in the EX/MEM pipeline register.
- Raises stall_o to freeze the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers while it sequences line transfers with the 256-bit off-chip data memory.
- Owns the tag, valid, dirty and data arrays.

Parameters:
- LINES, 32, number of cache lines (power of 2); index width IDX_W = log2(LINES).
- LINE_W, 256, line width in bits (8 words); byte offset width OFF_W = 5.
- ADDR_W, 32, byte address width; tag width TAG_W = ADDR_W - IDX_W - OFF_W (22 by default).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- cpu_rd_i  in  1  load request (EX/MEM MemRead).
- cpu_wr_i  in  1  store request (EX/MEM MemWrite); cpu_rd_i and cpu_wr_i are never both 1.
- cpu_addr_i  in  32  byte address (EX/MEM ALU result).
- cpu_wdata_i  in  32  store data.
- cpu_rdata_o  out  32  load data, valid when cpu_rd_i=1 and stall_o=0.
- stall_o  out  1  pipeline freeze.
- mem_en_o  out  1  memory request, level, held until ack.
- mem_we_o  out  1  1 = write-back, 0 = line fetch.
- mem_addr_o  out  32  line-aligned address, low 5 bits are 0.
- mem_wdata_o  out  256  victim line data.
- mem_rdata_i  in  256  fetched line.
- mem_ack_i  in  1  one-cycle completion pulse.

Behaviour:
- Address split: tag=addr[31:10], idx=addr[9:5], word=addr[4:2]. addr[1:0] is ignored; accesses are word-only.
- req = cpu_rd_i | cpu_wr_i.
- hit = valid[idx] & (tag_arr[idx]==tag). Evaluated combinationally.
- stall_o = req & (state!=IDLE | ~hit). Combinational, so the EX/MEM register holds in the same cycle the miss is detected.
- Read hit: cpu_rdata_o = word `word` of line `idx`, same cycle, zero added latency. cpu_rdata_o is 0 when there is no read hit.
- Write hit: at posedge, the word is replaced and dirty[idx] is set.
- FSM states: IDLE, WBACK, FETCH, FILL.
  - IDLE: if req & ~hit, go to WBACK when valid&dirty, else to FETCH. Latch tag, idx and victim tag into miss registers at this edge.
  - WBACK: mem_en_o=1, mem_we_o=1, mem_addr_o={victim_tag,idx,5'b0}, mem_wdata_o=data[idx]. On mem_ack_i go to FETCH.
  - FETCH: mem_en_o=1, mem_we_o=0, mem_addr_o={miss_tag,idx,5'b0}. On mem_ack_i, register mem_rdata_i and go to FILL.
  - FILL: write line, set tag, valid=1, dirty=0. Return to IDLE. The next cycle re-evaluates as a hit, which performs the load/store normally and deasserts stall_o.
- Miss latency: 3 cycles + memory latency (2 × memory latency for a dirty miss).
- mem_ack_i is sampled only in WBACK/FETCH and ignored elsewhere. An ack in the first cycle of mem_en_o is legal.
- In IDLE, mem_en_o=0, mem_we_o=0, mem_addr_o=0 and mem_wdata_o=0.
- req dropping mid-miss: the transfer still completes and the line is filled; stall_o follows its formula.
- Reset (asynchronous, at any time, including mid-transfer):
  - state=IDLE; all valid and dirty bits 0; miss registers 0.
  - stall_o=0 and all mem_* outputs=0 while rst_i=0.
  - Any in-flight memory transaction is abandoned.
  - Tag and data arrays are not reset.

Decomposition:
- Package dcache_pkg holds:
  - FSM state encoding (IDLE=0, WBACK=1, FETCH=2, FILL=3).
  - Field widths TAG_W, IDX_W, OFF_W.
  - Field-extract constants.
- Sub-module dcache_store holds the tag, valid, dirty and data arrays, with one combinational read port, a word-write port and a line-write port. It is the only place that implements the valid/dirty reset.

Test Plan:
1. Cold load of 0x0000_0040 with a memory model acking after 10 cycles.
   - Required: stall_o=1 from cycle 0; mem_en_o=1, mem_we_o=0, mem_addr_o=0x40.
   - After the ack + FILL, a hit returns the model's word 0; stall_o drops.
2. Store 0xDEADBEEF to 0x44 after scenario 1.
   - Required: no stall; a following load of 0x44 returns 0xDEADBEEF in the same cycle; dirty[2]=1.
3. Load 0x0000_0440, which conflicts on idx 2.
   - Required: WBACK with mem_addr_o=0x40, mem_wdata_o word 1 = 0xDEADBEEF.
   - Then FETCH with mem_addr_o=0x440; total stall = 2×latency + 3 cycles.
4. Memory acks in the same cycle mem_en_o rises.
   - Required: FETCH lasts one cycle; miss resolves in 4 cycles.
5. Assert rst_i=0 for 1 cycle during FETCH.
   - Required: mem_en_o=0 and stall_o=0 immediately.
   - A later ack is ignored; a re-issued load misses again.
6. Toggle mem_ack_i while in IDLE with req=0.
   - Required: no state change, mem_en_o stays 0.
